// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline hazard/stall controller: load-use bubbles, branch flush, dmem freeze, HALT drain.
module stall_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rs_d,
  input  logic [2:0]       rt_d,
  input  logic             valid_rs_d,
  input  logic             valid_rt_d,
  input  logic [2:0]       rd_e,
  input  logic             valid_rd_e,
  input  logic             mem_read_ex,
  input  logic             branch_taken_e,
  input  logic             dmem_stall,
  input  logic             halt_d,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             real_stall,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    MWAIT  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);
  localparam logic [2:0] DRAIN_INIT = 3'd3;

  state_t     cur, nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       lu_hazard;
  logic       pc_c, ifid_we_c, flush_c, bubble_c, stall_c, halted_c;

  assign lu_hazard = mem_read_ex & valid_rd_e &
                     ((valid_rs_d & (rs_d == rd_e)) | (valid_rt_d & (rt_d == rd_e)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= RUN;
      cnt <= 3'd0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    pc_c      = 1'b0;
    ifid_we_c = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    stall_c   = 1'b0;
    halted_c  = 1'b0;
    case (cur)
      // MWAIT with the memory released behaves exactly like RUN in that cycle
      RUN, MWAIT: begin
        if (dmem_stall) begin
          stall_c = 1'b1;
          nxt     = MWAIT;
        end else if (branch_taken_e) begin
          pc_c      = 1'b1;
          ifid_we_c = 1'b1;
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          cnt_nxt   = FLUSH_INIT;
          nxt       = (FLUSH_CYC == 1) ? RUN : FLUSH;
        end else if (lu_hazard) begin
          bubble_c = 1'b1;
          nxt      = RUN;
        end else if (halt_d) begin
          ifid_we_c = 1'b1;
          flush_c   = 1'b1;
          cnt_nxt   = DRAIN_INIT;
          nxt       = DRAIN;
        end else begin
          pc_c      = 1'b1;
          ifid_we_c = 1'b1;
          nxt       = RUN;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (dmem_stall) begin
          stall_c = 1'b1;
        end else begin
          pc_c      = 1'b1;
          ifid_we_c = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          if (cnt <= 3'd1) nxt = RUN;
        end
      end
      DRAIN: begin
        flush_c = 1'b1;
        if (dmem_stall) begin
          stall_c = 1'b1;
        end else begin
          ifid_we_c = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          if (cnt <= 3'd1) nxt = HALTED;
        end
      end
      default: begin
        stall_c  = 1'b1;
        halted_c = 1'b1;
      end
    endcase
  end

  // Reset overrides the Mealy outputs immediately, independent of the clock
  always_comb begin
    if (!rst_n) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      real_stall    = 1'b0;
      halted        = 1'b0;
    end else begin
      pc_write_en   = pc_c;
      ifid_write_en = ifid_we_c;
      ifid_flush    = flush_c;
      idex_bubble   = bubble_c;
      real_stall    = stall_c;
      halted        = halted_c;
    end
  end

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pc_c && !halted_c && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2, meaning total cycles ifid_flush is held after a taken branch (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of stall_count.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rs_d, rt_d  in  3 each  decode-stage source registers.
REQ-007 valid_rs_d, valid_rt_d  in  1 each  decode source actually read.
REQ-008 rd_e  in  3  execute-stage destination register.
REQ-009 valid_rd_e, mem_read_ex  in  1 each  execute destination valid / execute instruction is a load.
REQ-010 branch_taken_e  in  1  branch/jump resolved taken in execute.
REQ-011 dmem_stall  in  1  data memory busy; whole pipe must freeze.
REQ-012 halt_d  in  1  HALT instruction in decode.
REQ-013 pc_write_en, ifid_write_en  out  1 each  PC / IF-ID register update enables.
REQ-014 ifid_flush, idex_bubble  out  1 each  load NOP into IF-ID / ID-EX.
REQ-015 real_stall  out  1  freeze execute output and EX-MEM register.
REQ-016 halted  out  1  pipeline drained after HALT.
REQ-017 state  out  3  FSM state, for debug.
REQ-018 stall_count  out  CNT_W  saturating count of frozen-PC cycles.

Function
REQ-019 lu_hazard SHALL = mem_read_ex & valid_rd_e & ((valid_rs_d & rs_d==rd_e) | (valid_rt_d & rt_d==rd_e)).
REQ-020 States SHALL be RUN=0, MWAIT=1, FLUSH=2, DRAIN=3, HALTED=4; outputs are Mealy (same-cycle).
REQ-021 RUN priority SHALL be dmem_stall > branch_taken_e > lu_hazard > halt_d > normal.
REQ-022 RUN+dmem_stall: pc_write_en=0, ifid_write_en=0, real_stall=1, flush=bubble=0; next MWAIT.
REQ-023 RUN+branch_taken_e: pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_bubble=1; next FLUSH with flush counter=FLUSH_CYC-1, or RUN if FLUSH_CYC=1.
REQ-024 RUN+lu_hazard: pc_write_en=0, ifid_write_en=0, idex_bubble=1, real_stall=0; next RUN (one bubble per hazard-cycle).
REQ-025 RUN+halt_d: pc_write_en=0, ifid_flush=1, ifid_write_en=1; next DRAIN with drain counter=3.
REQ-026 RUN normal: pc_write_en=ifid_write_en=1, all others 0.
REQ-027 MWAIT SHALL drive the REQ-022 outputs while dmem_stall=1, ignoring branch/hazard/halt inputs; when dmem_stall=0, act exactly as RUN in that cycle (same outputs and next state).
REQ-028 FLUSH: pc_write_en=ifid_write_en=ifid_flush=1, idex_bubble=0; decrement counter; next RUN when counter reaches 0.
REQ-029 DRAIN: pc_write_en=0, ifid_flush=1; decrement counter; next HALTED when counter reaches 0.
REQ-030 In FLUSH or DRAIN, dmem_stall=1 SHALL force pc_write_en=ifid_write_en=0 and real_stall=1, hold the counter, and keep the state.
REQ-031 HALTED: pc_write_en=ifid_write_en=0, ifid_flush=idex_bubble=0, real_stall=1, halted=1; terminal until reset.
REQ-032 halted SHALL be 0 in all other states.
REQ-033 stall_count SHALL increment each cycle pc_write_en=0 and state!=HALTED, saturating at all-ones.
REQ-034 Encodings 5-7 SHALL behave as HALTED.

Reset
REQ-035 rst_n=0 SHALL immediately force state=RUN, counters=0, stall_count=0.
REQ-036 rst_n=0 SHALL immediately force outputs pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1, real_stall=0, halted=0.
REQ-037 Reset deassertion SHALL take effect at the next clk edge; reset mid-FLUSH/DRAIN SHALL abandon the sequence.

Verification
REQ-038 Load rd_e=3, mem_read_ex=1, valid_rd_e=1, rs_d=3, valid_rs_d=1 for 1 cycle -> pc_write_en=0, idex_bubble=1 that cycle; RUN next cycle; stall_count=1.
REQ-039 branch_taken_e=1 for 1 cycle, FLUSH_CYC=2 -> ifid_flush=1 for 2 cycles, idex_bubble=1 only in the first; state RUN on cycle 3.
REQ-040 branch_taken_e and lu_hazard together -> branch wins: pc_write_en=1, idex_bubble=1; stall_count unchanged.
REQ-041 dmem_stall=1 for 4 cycles during FLUSH with counter=1 -> real_stall=1 for 4 cycles, counter held; FLUSH ends 1 cycle after the stall drops.
REQ-042 halt_d=1 -> 3 DRAIN cycles, then halted=1 and state=4; stall_count=4 and frozen thereafter.
REQ-043 rst_n=0 asserted mid-DRAIN -> same-cycle state=0, halted=0, stall_count=0.
